dcache_port_arbiter: RTL
========================

# dcache_port_arbiter

Arbitrates the single data-cache request port between the load path of the memory stage and the drain port of the store buffer. It replaces the combinational "store wins, load stalls" mux in the memory stage with a registered three-state scheduler. The scheduler locks the port for the full duration of each dcache access and prevents store-buffer starvation under long load streams. It sits between the memory-stage/store-buffer requesters and `new_dcache`.

## Interface
Parameters:
- `MAX_STARVE`, default 4: consecutive load grants allowed while a store is waiting before the store is forced; range 1..15.

Ports:
- `clk_i` in 1: clock; all state updates on its rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `ld_valid_i` in 1: load request; held with `ld_addr_i` stable until `ld_ready_o` or `ld_kill_i`.
- `ld_addr_i` in 32: load byte address.
- `ld_kill_i` in 1: the in-flight or pending load is no longer alive (squashed).
- `ld_ready_o` out 1: one-cycle pulse; load complete, `ld_data_o` valid.
- `ld_data_o` out 32: load data, equal to `dc_data_rd_i` in the `ld_ready_o` cycle.
- `st_valid_i` in 1: store-buffer drain request; held with address and data stable until `st_ready_o`.
- `st_addr_i` in 32: store address.
- `st_data_i` in 32: store data.
- `sb_full_i` in 1: store buffer full; forces store priority.
- `st_ready_o` out 1: one-cycle pulse; store written to the dcache.
- `dc_valid_o` out 1: request to the dcache.
- `dc_we_o` out 1: 1 = store, 0 = load.
- `dc_addr_o` out 32: dcache address.
- `dc_data_wr_o` out 32: dcache write data.
- `dc_ready_i` in 1: dcache access complete.
- `dc_data_rd_i` in 32: dcache read data.

## Operation
- States: `IDLE`, `LD_BUSY`, `ST_BUSY`.
- `IDLE`:
  - Evaluate requests. A load is eligible when `ld_valid_i && !ld_kill_i`.
  - Store wins if `st_valid_i` and any of these holds: `sb_full_i`, `starve_cnt == MAX_STARVE`, or no eligible load.
  - Otherwise an eligible load wins.
  - The winner's address, data and we are latched into registers; the next state is `LD_BUSY` or `ST_BUSY`.
  - With no request, stay in `IDLE`.
- `LD_BUSY`/`ST_BUSY`:
  - `dc_valid_o=1`, and `dc_addr_o/dc_data_wr_o/dc_we_o` are driven from the latched registers only (requester input changes are ignored).
  - On `dc_ready_i`, the matching ready output is driven combinationally for that cycle and the next state is `IDLE`.
- Kill: `ld_kill_i` in `LD_BUSY` sets `killed`. The dcache access still completes, since a dcache access cannot be aborted. `ld_ready_o` is suppressed for that completion; `killed` clears on return to `IDLE`. If `ld_kill_i` and `dc_ready_i` arrive in the same cycle, `ld_ready_o` is also suppressed.
- Starvation counter `starve_cnt`, 4 bits, saturating at `MAX_STARVE`:
  - Increments on each load grant taken while `st_valid_i=1`.
  - Clears to 0 on every store grant.
- Stores are never killed by this block; discard is handled inside the store buffer before the request is raised.

## Timing
- Reset values:
  - State `IDLE`.
  - `starve_cnt=0`, `killed=0`.
  - Outputs `dc_valid_o=0`, `dc_we_o=0`, `dc_addr_o=0`, `dc_data_wr_o=0`, `ld_ready_o=0`, `st_ready_o=0`, `ld_data_o=0`.
- Reset asserted mid-access: the access is abandoned with no ready pulse; the dcache is reset in the same cycle.
- Latency:
  - Request seen in `IDLE` at cycle N gives `dc_valid_o` at N+1.
  - With a dcache hit (`dc_ready_i` at N+1), `ld_ready_o`/`st_ready_o` pulses at N+1.
  - Each miss cycle adds one cycle.
- Throughput: a mandatory `IDLE` bubble after every completion gives at most one access per 2 cycles. This lets requesters drop or change `valid` after the ready pulse.
- `ld_data_o` is valid only in the `ld_ready_o` cycle. In all other cycles it holds 0.
- `dc_ready_i` while in `IDLE` is ignored.

## Configuration
- `DCACHE_ARB_STARVE_GUARD_EN`:
  - Defined: `starve_cnt` and the `MAX_STARVE` forcing rule are compiled in.
  - Undefined: the counter is removed, and loads always win unless `sb_full_i` is set or no eligible load exists. `MAX_STARVE` is then unused.

## Test plan
- Load only, addr 0x100, `dc_ready_i` high at first busy cycle -> `dc_valid_o`, `dc_we_o=0` at N+1; `ld_ready_o` pulse at N+1 with `ld_data_o=dc_data_rd_i=0xDEADBEEF`.
- Load and store both valid in `IDLE`, `sb_full_i=0`, cnt 0 -> load granted first. After completion and bubble, store granted with `dc_we_o=1` and `dc_data_wr_o=st_data_i=0x12345678`.
- Guard defined, `MAX_STARVE=4`, continuous loads plus pending store -> 4 load grants, then the store is granted on the 5th arbitration and `starve_cnt` returns to 0. Guard undefined -> the store is never granted until loads stop.
- `sb_full_i=1` with both requests -> store granted immediately regardless of `starve_cnt`.
- Load in `LD_BUSY` with 3-cycle miss, `ld_kill_i` pulsed on miss cycle 1 -> `dc_valid_o` held until `dc_ready_i`, no `ld_ready_o` pulse, `IDLE` next cycle.
- `rst_i` asserted during `ST_BUSY` -> next cycle `IDLE`, all outputs 0, no `st_ready_o`.

Source files
------------

// File: rtl/dcache_port_arbiter_if.sv
// Bundle of the load, store-drain and dcache port signals seen by the arbiter.
// The slave view belongs to the arbiter and the master view to its surroundings.
interface dcache_port_arbiter_if;
    logic        ld_valid_i;
    logic [31:0] ld_addr_i;
    logic        ld_kill_i;
    logic        ld_ready_o;
    logic [31:0] ld_data_o;
    logic        st_valid_i;
    logic [31:0] st_addr_i;
    logic [31:0] st_data_i;
    logic        sb_full_i;
    logic        st_ready_o;
    logic        dc_valid_o;
    logic        dc_we_o;
    logic [31:0] dc_addr_o;
    logic [31:0] dc_data_wr_o;
    logic        dc_ready_i;
    logic [31:0] dc_data_rd_i;

    modport slave (
        input  ld_valid_i, ld_addr_i, ld_kill_i,
        input  st_valid_i, st_addr_i, st_data_i, sb_full_i,
        input  dc_ready_i, dc_data_rd_i,
        output ld_ready_o, ld_data_o, st_ready_o,
        output dc_valid_o, dc_we_o, dc_addr_o, dc_data_wr_o
    );

    modport master (
        output ld_valid_i, ld_addr_i, ld_kill_i,
        output st_valid_i, st_addr_i, st_data_i, sb_full_i,
        output dc_ready_i, dc_data_rd_i,
        input  ld_ready_o, ld_data_o, st_ready_o,
        input  dc_valid_o, dc_we_o, dc_addr_o, dc_data_wr_o
    );
endinterface

// File: rtl/dcache_port_arbiter.sv
// Registered IDLE/LD_BUSY/ST_BUSY scheduler for the shared dcache request port.
// Define DCACHE_ARB_STARVE_GUARD_EN to compile in the store-starvation guard.
module dcache_port_arbiter #(
    parameter int unsigned MAX_STARVE = 4
) (
    input logic                  clk_i,
    input logic                  rst_i,
    dcache_port_arbiter_if.slave bus
);

    if (MAX_STARVE < 1 || MAX_STARVE > 15) begin : g_bad_max_starve
        $error("MAX_STARVE must be in 1..15");
    end

    typedef enum logic [1:0] {
        IDLE,
        LD_BUSY,
        ST_BUSY
    } state_e;

    state_e      state_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic        killed_q;

    logic ld_elig;
    logic st_force;
    logic st_win;

`ifdef DCACHE_ARB_STARVE_GUARD_EN
    localparam logic [3:0] StarveMax = 4'(MAX_STARVE);
    logic [3:0] starve_q;
    assign st_force = bus.sb_full_i || (starve_q == StarveMax);
`else
    assign st_force = bus.sb_full_i;
`endif

    assign ld_elig = bus.ld_valid_i && !bus.ld_kill_i;
    assign st_win  = bus.st_valid_i && (st_force || !ld_elig);

    assign bus.dc_valid_o   = (state_q != IDLE);
    assign bus.dc_we_o      = we_q;
    assign bus.dc_addr_o    = addr_q;
    assign bus.dc_data_wr_o = data_q;

    // A reset cycle abandons the access, so no ready pulse may escape it
    assign bus.ld_ready_o = (state_q == LD_BUSY) && bus.dc_ready_i &&
                            !killed_q && !bus.ld_kill_i && !rst_i;
    assign bus.st_ready_o = (state_q == ST_BUSY) && bus.dc_ready_i && !rst_i;
    assign bus.ld_data_o  = bus.ld_ready_o ? bus.dc_data_rd_i : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            killed_q <= 1'b0;
`ifdef DCACHE_ARB_STARVE_GUARD_EN
            starve_q <= '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (st_win) begin
                        state_q <= ST_BUSY;
                        we_q    <= 1'b1;
                        addr_q  <= bus.st_addr_i;
                        data_q  <= bus.st_data_i;
`ifdef DCACHE_ARB_STARVE_GUARD_EN
                        starve_q <= '0;
`endif
                    end else if (ld_elig) begin
                        state_q <= LD_BUSY;
                        we_q    <= 1'b0;
                        addr_q  <= bus.ld_addr_i;
                        data_q  <= '0;
`ifdef DCACHE_ARB_STARVE_GUARD_EN
                        if (bus.st_valid_i && starve_q != StarveMax)
                            starve_q <= starve_q + 4'd1;
`endif
                    end
                end
                LD_BUSY, ST_BUSY: begin
                    if (state_q == LD_BUSY && bus.ld_kill_i)
                        killed_q <= 1'b1;
                    // Latches clear on completion so the port idles at zero
                    if (bus.dc_ready_i) begin
                        state_q  <= IDLE;
                        we_q     <= 1'b0;
                        addr_q   <= '0;
                        data_q   <= '0;
                        killed_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
